// File: rtl/pacman_pkg.sv
// Shared definitions for the pac-man game blocks: game state encoding,
// screen geometry, default sprite size and coordinate width.
package pacman_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned COORD_W     = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    RESPAWN,
    PLAY,
    FREEZE,
    GAME_OVER
  } state_t;

  // Absolute difference of two screen coordinates, taken in COORD_W+1 bit
  // signed arithmetic so that no wrap can occur.
  function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[COORD_W]) d = -d;
    return $unsigned(d);
  endfunction

endpackage

// File: rtl/collision_manager_if.sv
// Bundle of the collision manager's position inputs and HUD/mover outputs.
// master: the side producing frame_tick, game_start and positions.
// slave:  the collision manager itself.
interface collision_manager_if
  import pacman_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS = 4
) ();

  logic                          frame_tick;
  logic                          game_start;
  coord_t                        pac_x;
  coord_t                        pac_y;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y;
  logic                          soft_reset;
  logic                          freeze;
  logic [3:0]                    lives;
  logic                          game_over;
  logic [NUM_GHOSTS-1:0]         hit_mask;
  logic                          invuln;

  modport master (
    output frame_tick, game_start, pac_x, pac_y, ghost_x, ghost_y,
    input  soft_reset, freeze, lives, game_over, hit_mask, invuln
  );

  modport slave (
    input  frame_tick, game_start, pac_x, pac_y, ghost_x, ghost_y,
    output soft_reset, freeze, lives, game_over, hit_mask, invuln
  );

endinterface

// File: rtl/collision_manager_box_overlap.sv
// Combinational bounding-box overlap test between two square sprites of
// edge SIZE. Boxes that merely touch (difference == SIZE) do not overlap.
module box_overlap
  import pacman_pkg::*;
#(
  parameter int unsigned SIZE = SPRITE_SIZE
) (
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  output logic   overlap
);

  localparam logic [COORD_W:0] SIZE_W = SIZE[COORD_W:0];

  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;

  // Per-axis distance compared strictly against the sprite size.
  always_comb begin
    dx      = abs_diff(ax, bx);
    dy      = abs_diff(ay, by);
    overlap = (dx < SIZE_W) && (dy < SIZE_W);
  end

endmodule

// File: rtl/collision_manager.sv
// Pac-man vs. ghost collision detection and life/respawn state machine.
// Acts on overlaps only on frame_tick while in PLAY; drives soft_reset,
// freeze, lives, game_over, hit_mask and invuln (all registered).
// Optional feature macro: PACMAN_INVULN_EN (post-respawn immunity counter).
module collision_manager
  import pacman_pkg::*;
#(
  parameter int unsigned SIZE          = SPRITE_SIZE,
  parameter int unsigned NUM_GHOSTS    = 4,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input logic                clk,
  input logic                rst,
  collision_manager_if.slave bus
);

  localparam int unsigned CNT_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] FRZ_LAST = CNT_W'(FREEZE_FRAMES - 1);

  state_t                state;
  logic [CNT_W-1:0]      frame_cnt;
  logic [NUM_GHOSTS-1:0] overlap;
  logic                  hit;
  logic                  inv_q;

  logic                  soft_reset_q;
  logic                  freeze_q;
  logic [3:0]            lives_q;
  logic                  game_over_q;
  logic [NUM_GHOSTS-1:0] hit_mask_q;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    box_overlap #(.SIZE(SIZE)) u_box (
      .ax      (bus.pac_x),
      .ay      (bus.pac_y),
      .bx      (bus.ghost_x[g*COORD_W +: COORD_W]),
      .by      (bus.ghost_y[g*COORD_W +: COORD_W]),
      .overlap (overlap[g])
    );
  end

  // A hit needs a frame tick, at least one overlapping ghost, and no immunity.
  always_comb begin
    hit = bus.frame_tick && (|overlap) && !inv_q;
  end

  // Life/respawn state machine; outputs are updated together with the state
  // so that they are a registered view of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      soft_reset_q <= 1'b0;
      freeze_q     <= 1'b1;
      lives_q      <= '0;
      game_over_q  <= 1'b0;
      hit_mask_q   <= '0;
    end else begin
      soft_reset_q <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (bus.game_start) begin
            state        <= RESPAWN;
            lives_q      <= LIVES_INIT[3:0];
            hit_mask_q   <= '0;
            frame_cnt    <= '0;
            soft_reset_q <= 1'b1;
            freeze_q     <= 1'b1;
            game_over_q  <= 1'b0;
          end
        end
        RESPAWN: begin
          state    <= PLAY;
          freeze_q <= 1'b0;
        end
        PLAY: begin
          if (hit) begin
            hit_mask_q <= overlap;
            if (lives_q != '0) lives_q <= lives_q - 1'b1;
            frame_cnt  <= '0;
            state      <= FREEZE;
            freeze_q   <= 1'b1;
          end
        end
        FREEZE: begin
          if (bus.frame_tick) begin
            if (frame_cnt == FRZ_LAST) begin
              frame_cnt <= '0;
              if (lives_q == '0) begin
                state       <= GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state        <= RESPAWN;
                soft_reset_q <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PACMAN_INVULN_EN
  localparam int unsigned INV_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;

  logic [INV_W-1:0] inv_cnt;

  // Immunity window: loaded when leaving RESPAWN, counts PLAY frame ticks;
  // invuln drops on the same edge the counter reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_cnt <= '0;
      inv_q   <= 1'b0;
    end else if (state == RESPAWN) begin
      inv_cnt <= INV_W'(INVULN_FRAMES);
      inv_q   <= (INVULN_FRAMES != 0);
    end else if (state == IDLE || state == GAME_OVER) begin
      inv_cnt <= '0;
      inv_q   <= 1'b0;
    end else if (state == PLAY && bus.frame_tick && inv_cnt != '0) begin
      inv_cnt <= inv_cnt - 1'b1;
      if (inv_cnt == INV_W'(1)) inv_q <= 1'b0;
    end
  end
`else
  logic unused_invuln_cfg;
  assign unused_invuln_cfg = ^INVULN_FRAMES;
  assign inv_q             = 1'b0;
`endif

  assign bus.soft_reset = soft_reset_q;
  assign bus.freeze     = freeze_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;
  assign bus.hit_mask   = hit_mask_q;
  assign bus.invuln     = inv_q;

endmodule
